mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3, meaning the number of consecutive LS grants allowed while an IF request waits.
REQ-002 SHALL have port clk, in, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, in, 1, the reset: asynchronous and active-low.
REQ-004 SHALL have IF-side ports:
- if_req, in, 1: fetch request.
- if_addr, in, 32: fetch address.
- if_ready, out, 1: IF slot empty.
- if_done, out, 1: one-cycle fetch-complete pulse.
- if_pc, out, 32: address of the completed fetch.
- if_inst, out, 32: fetched word.
REQ-005 SHALL have port flush, in, 1, which cancels pending and in-flight fetches.
REQ-006 SHALL have LS-side ports:
- ls_req, in, 1: load/store request.
- ls_addr, in, 32: load/store address.
- ls_wdata, in, 32: store data.
- ls_type, in, 4: access type code, passed through unchanged.
- ls_ready, out, 1: LS slot empty.
- ls_done, out, 1: one-cycle completion pulse.
- ls_rdata, out, 32: load data.
REQ-007 SHALL have downstream memory-controller ports:
- mc_req, out, 1: request valid.
- mc_addr, out, 32: request address.
- mc_wdata, out, 32: store data.
- mc_type, out, 4: access type.
- mc_is_if, out, 1: 1 for a fetch, 0 for a load/store.
- mc_busy, in, 1: controller cannot accept.
- mc_done, in, 1: one-cycle completion pulse.
- mc_rdata, in, 32: read data.
REQ-008 SHALL have port arb_busy, out, 1, high whenever the FSM is not IDLE.

Function
REQ-009 SHALL hold one pending slot per requester (valid, addr, plus wdata/type for LS).
- A request is accepted when req && ready at a clock edge.
- ready = !slot_valid.
REQ-010 SHALL implement FSM states:
- IDLE: no transaction outstanding.
- ISSUE: mc_req asserted.
- WAIT: awaiting mc_done.
- DROP: a flushed fetch is in flight.
REQ-011 In IDLE with at least one slot valid, SHALL select a winner at the edge, clear that slot and enter ISSUE with mc_* driven from registers.
REQ-012 SHALL arbitrate as follows:
- LS wins over IF.
- Exception: IF wins when starve_cnt == STARVE_LIMIT.
- starve_cnt (2 bits, saturating) increments on each LS selection while the IF slot is valid.
- starve_cnt clears when IF is selected or the IF slot is flushed.
REQ-013 In ISSUE, SHALL hold mc_req=1 and stable mc_* until an edge with mc_busy=0, then enter WAIT with mc_req=0.
REQ-014 In WAIT, on the edge with mc_done=1, SHALL return to IDLE and, on the following cycle, pulse exactly one completion:
- For a fetch: if_done=1, with if_inst=mc_rdata and if_pc=the issued addr.
- For a load/store: ls_done=1, with ls_rdata=mc_rdata.
REQ-015 SHALL ignore mc_done while in IDLE or ISSUE.
REQ-016 Minimum latency from accept to done-pulse is 4 cycles:
- accept E0, select E1, handshake E2, mc_done E3, done visible after E3.
REQ-017 On flush=1 at an edge, SHALL respond by state:
- Clear the IF slot; if_req in that same cycle is not accepted.
- A fetch in ISSUE is withdrawn: mc_req=0 next cycle, return to IDLE.
- A fetch in WAIT moves the FSM to DROP.
REQ-018 In DROP, SHALL wait for mc_done, discard the data without asserting if_done, then return to IDLE.
REQ-019 flush SHALL NOT affect the LS slot or an LS transaction in any state.
REQ-020 When flush and mc_done coincide in WAIT for a fetch, SHALL suppress if_done and go to IDLE.
REQ-021 When both requests arrive in the same cycle with both slots empty, SHALL accept both; the LS request is issued first unless the starvation rule applies.
REQ-022 if_done and ls_done SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle.
REQ-023 if_inst, if_pc and ls_rdata SHALL hold their values until the next completion of the same kind.

Reset
REQ-024 While rst=0, SHALL force:
- FSM to IDLE, both slots invalid, starve_cnt=0.
- mc_req=0, mc_addr=0, mc_wdata=0, mc_type=0, mc_is_if=0.
- if_done=0, ls_done=0, if_inst=0, if_pc=0, ls_rdata=0, arb_busy=0.
- if_ready=1, ls_ready=1.
REQ-025 Reset asserted mid-transaction SHALL abandon the transaction silently, with no done pulse after release.

Verification
REQ-026 Single fetch:
- Stimulus: if_req with if_addr=0x100; mc_busy=0; mc_done 1 cycle after handshake with mc_rdata=0x00000513.
- Response: mc_is_if=1, mc_addr=0x100; one-cycle if_done with if_pc=0x100 and if_inst=0x00000513, 4 cycles after accept.
REQ-027 Simultaneous requests:
- Stimulus: if_req(0x200) and ls_req(0x1000, type SW, wdata=0xDEADBEEF) in the same cycle.
- Response: first mc_req carries addr 0x1000, wdata 0xDEADBEEF, mc_is_if=0; the second carries 0x200 with mc_is_if=1; ls_done precedes if_done.
REQ-028 Starvation:
- Stimulus: keep the LS slot refilled continuously while one IF request waits, STARVE_LIMIT=3.
- Response: IF is issued after exactly 3 LS transactions.
REQ-029 Flush cases:
- Flush in WAIT of a fetch, then mc_done with rdata 0x12345678 -> no if_done; arb_busy high until after that mc_done.
- Flush in ISSUE -> mc_req drops next cycle.
REQ-030 Backpressure and reset:
- Hold mc_busy=1 for 5 cycles in ISSUE -> mc_req and mc_addr stable for all 5 cycles.
- Pulse rst=0 during WAIT -> all outputs at reset values immediately (asynchronously); no done pulse after release.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Memory-controller bus between the arbiter and the downstream controller.
//   master (arbiter)   : drives mc_req/mc_addr/mc_wdata/mc_type/mc_is_if,
//                        samples mc_busy/mc_done/mc_rdata
//   slave  (controller): the mirror image
// mc_req is held with stable payload until an edge with mc_busy=0;
// mc_done is a one-cycle completion pulse carrying mc_rdata.
interface mem_arbiter_if;
    logic        mc_req;
    logic [31:0] mc_addr;
    logic [31:0] mc_wdata;
    logic [3:0]  mc_type;
    logic        mc_is_if;
    logic        mc_busy;
    logic        mc_done;
    logic [31:0] mc_rdata;

    modport master (
        output mc_req, mc_addr, mc_wdata, mc_type, mc_is_if,
        input  mc_busy, mc_done, mc_rdata
    );

    modport slave (
        input  mc_req, mc_addr, mc_wdata, mc_type, mc_is_if,
        output mc_busy, mc_done, mc_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch (IF) and load/store (LS)
// share one memory controller. Each requester owns a single pending slot;
// LS has priority, but after STARVE_LIMIT consecutive LS grants taken while
// an IF request waits, the IF request wins. flush cancels pending and
// in-flight fetches and never touches LS traffic.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   if_*              : fetch request in, ready/done/pc/inst out
//   flush             : cancel fetches
//   ls_*              : load/store request in, ready/done/rdata out
//   mc                : memory-controller bus (master side)
//   arb_busy          : high whenever a transaction is outstanding
module mem_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req,
    input  logic [31:0]          if_addr,
    output logic                 if_ready,
    output logic                 if_done,
    output logic [31:0]          if_pc,
    output logic [31:0]          if_inst,
    input  logic                 flush,
    input  logic                 ls_req,
    input  logic [31:0]          ls_addr,
    input  logic [31:0]          ls_wdata,
    input  logic [3:0]           ls_type,
    output logic                 ls_ready,
    output logic                 ls_done,
    output logic [31:0]          ls_rdata,
    mem_arbiter_if.master        mc,
    output logic                 arb_busy
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DROP} state_t;

    localparam logic [1:0] STARVE_MAX = 2'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_addr_q, if_addr_d;
    logic        ls_valid_q, ls_valid_d;
    logic [31:0] ls_addr_q, ls_addr_d;
    logic [31:0] ls_wdata_q, ls_wdata_d;
    logic [3:0]  ls_type_q, ls_type_d;
    logic [1:0]  starve_q, starve_d;
    logic        mc_req_q, mc_req_d;
    logic [31:0] mc_addr_q, mc_addr_d;
    logic [31:0] mc_wdata_q, mc_wdata_d;
    logic [3:0]  mc_type_q, mc_type_d;
    logic        mc_is_if_q, mc_is_if_d;
    logic        if_done_q, if_done_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic        ls_done_q, ls_done_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
    logic        if_cand;
    logic        pick_if;

    always_comb begin
        state_d    = state_q;
        if_valid_d = if_valid_q;
        if_addr_d  = if_addr_q;
        ls_valid_d = ls_valid_q;
        ls_addr_d  = ls_addr_q;
        ls_wdata_d = ls_wdata_q;
        ls_type_d  = ls_type_q;
        starve_d   = starve_q;
        mc_req_d   = mc_req_q;
        mc_addr_d  = mc_addr_q;
        mc_wdata_d = mc_wdata_q;
        mc_type_d  = mc_type_q;
        mc_is_if_d = mc_is_if_q;
        if_done_d  = 1'b0;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        ls_done_d  = 1'b0;
        ls_rdata_d = ls_rdata_q;

        // A fetch flushed at this very edge is no longer a candidate.
        if_cand = if_valid_q && !flush;
        pick_if = if_cand && (!ls_valid_q || starve_q == STARVE_MAX);

        // Slot fill; only possible while the slot is empty, so it never
        // collides with the selection below, which needs a full slot.
        if (!if_valid_q && if_req && !flush) begin
            if_valid_d = 1'b1;
            if_addr_d  = if_addr;
        end
        if (!ls_valid_q && ls_req) begin
            ls_valid_d = 1'b1;
            ls_addr_d  = ls_addr;
            ls_wdata_d = ls_wdata;
            ls_type_d  = ls_type;
        end

        case (state_q)
            S_IDLE: begin
                if (if_cand || ls_valid_q) begin
                    mc_req_d = 1'b1;
                    state_d  = S_ISSUE;
                    if (pick_if) begin
                        if_valid_d = 1'b0;
                        starve_d   = 2'd0;
                        mc_addr_d  = if_addr_q;
                        mc_wdata_d = 32'd0;
                        mc_type_d  = 4'd0;
                        mc_is_if_d = 1'b1;
                    end else begin
                        ls_valid_d = 1'b0;
                        mc_addr_d  = ls_addr_q;
                        mc_wdata_d = ls_wdata_q;
                        mc_type_d  = ls_type_q;
                        mc_is_if_d = 1'b0;
                        if (if_cand && starve_q != 2'd3)
                            starve_d = starve_q + 2'd1;
                    end
                end
            end
            S_ISSUE: begin
                if (mc_is_if_q && flush) begin
                    mc_req_d = 1'b0;
                    // If the controller took the request on this same edge
                    // a completion is still coming; swallow it in DROP so it
                    // cannot be mistaken for the next transaction's data.
                    state_d  = mc.mc_busy ? S_IDLE : S_DROP;
                end else if (!mc.mc_busy) begin
                    mc_req_d = 1'b0;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mc.mc_done) begin
                    state_d = S_IDLE;
                    if (mc_is_if_q) begin
                        if (!flush) begin
                            if_done_d = 1'b1;
                            if_inst_d = mc.mc_rdata;
                            if_pc_d   = mc_addr_q;
                        end
                    end else begin
                        ls_done_d  = 1'b1;
                        ls_rdata_d = mc.mc_rdata;
                    end
                end else if (mc_is_if_q && flush) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (mc.mc_done)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            if_valid_d = 1'b0;
            starve_d   = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            if_valid_q <= 1'b0;
            if_addr_q  <= 32'd0;
            ls_valid_q <= 1'b0;
            ls_addr_q  <= 32'd0;
            ls_wdata_q <= 32'd0;
            ls_type_q  <= 4'd0;
            starve_q   <= 2'd0;
            mc_req_q   <= 1'b0;
            mc_addr_q  <= 32'd0;
            mc_wdata_q <= 32'd0;
            mc_type_q  <= 4'd0;
            mc_is_if_q <= 1'b0;
            if_done_q  <= 1'b0;
            if_pc_q    <= 32'd0;
            if_inst_q  <= 32'd0;
            ls_done_q  <= 1'b0;
            ls_rdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            if_valid_q <= if_valid_d;
            if_addr_q  <= if_addr_d;
            ls_valid_q <= ls_valid_d;
            ls_addr_q  <= ls_addr_d;
            ls_wdata_q <= ls_wdata_d;
            ls_type_q  <= ls_type_d;
            starve_q   <= starve_d;
            mc_req_q   <= mc_req_d;
            mc_addr_q  <= mc_addr_d;
            mc_wdata_q <= mc_wdata_d;
            mc_type_q  <= mc_type_d;
            mc_is_if_q <= mc_is_if_d;
            if_done_q  <= if_done_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            ls_done_q  <= ls_done_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign if_ready    = !if_valid_q;
    assign ls_ready    = !ls_valid_q;
    assign if_done     = if_done_q;
    assign if_pc       = if_pc_q;
    assign if_inst     = if_inst_q;
    assign ls_done     = ls_done_q;
    assign ls_rdata    = ls_rdata_q;
    assign arb_busy    = (state_q != S_IDLE);
    assign mc.mc_req   = mc_req_q;
    assign mc.mc_addr  = mc_addr_q;
    assign mc.mc_wdata = mc_wdata_q;
    assign mc.mc_type  = mc_type_q;
    assign mc.mc_is_if = mc_is_if_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single fetch, simultaneous requests,
// starvation, flush cases, backpressure and asynchronous reset.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, flush, ls_req;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic [3:0]  ls_type;
    logic        if_ready, if_done, ls_ready, ls_done, arb_busy;
    logic [31:0] if_pc, if_inst, ls_rdata;

    int errors = 0;
    int checks = 0;

    mem_arbiter_if mc ();

    mem_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_done(if_done), .if_pc(if_pc), .if_inst(if_inst),
        .flush(flush),
        .ls_req(ls_req), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_type(ls_type), .ls_ready(ls_ready), .ls_done(ls_done),
        .ls_rdata(ls_rdata),
        .mc(mc),
        .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-22s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ls_before;
        logic got_if;

        if_req = 0; if_addr = 0; flush = 0; ls_req = 0; ls_addr = 0;
        ls_wdata = 0; ls_type = 0;
        mc.mc_busy = 0; mc.mc_done = 0; mc.mc_rdata = 0;
        rst = 1;
        #2 rst = 0;
        tick(); tick();
        // Reset state
        chk("rst_if_ready", if_ready, 1);
        chk("rst_ls_ready", ls_ready, 1);
        chk("rst_mc_req", mc.mc_req, 0);
        chk("rst_arb_busy", arb_busy, 0);
        chk("rst_if_pc", if_pc, 0);
        rst = 1;
        tick();

        // Single fetch: done 4 edges after accept
        if_req = 1; if_addr = 32'h100;
        tick();                                   // E0 accept
        if_req = 0;
        chk("f1_if_ready_low", if_ready, 0);
        tick();                                   // E1 select
        chk("f1_mc_req", mc.mc_req, 1);
        chk("f1_mc_is_if", mc.mc_is_if, 1);
        chk("f1_mc_addr", mc.mc_addr, 32'h100);
        chk("f1_arb_busy", arb_busy, 1);
        tick();                                   // E2 handshake
        chk("f1_mc_req_drop", mc.mc_req, 0);
        mc.mc_done = 1; mc.mc_rdata = 32'h00000513;
        tick();                                   // E3 mc_done
        mc.mc_done = 0;
        chk("f1_if_done", if_done, 1);
        chk("f1_if_pc", if_pc, 32'h100);
        chk("f1_if_inst", if_inst, 32'h00000513);
        chk("f1_ls_done", ls_done, 0);
        tick();
        chk("f1_if_done_pulse", if_done, 0);
        chk("f1_if_inst_hold", if_inst, 32'h00000513);

        // Simultaneous IF and LS: LS first
        if_req = 1; if_addr = 32'h200;
        ls_req = 1; ls_addr = 32'h1000; ls_wdata = 32'hDEADBEEF; ls_type = 4'h2;
        tick();
        if_req = 0; ls_req = 0;
        chk("sim_if_ready", if_ready, 0);
        chk("sim_ls_ready", ls_ready, 0);
        tick();
        chk("sim1_mc_addr", mc.mc_addr, 32'h1000);
        chk("sim1_mc_wdata", mc.mc_wdata, 32'hDEADBEEF);
        chk("sim1_mc_type", mc.mc_type, 4'h2);
        chk("sim1_mc_is_if", mc.mc_is_if, 0);
        tick();
        mc.mc_done = 1; mc.mc_rdata = 32'hCAFE0001;
        tick();
        mc.mc_done = 0;
        chk("sim1_ls_done", ls_done, 1);
        chk("sim1_if_done", if_done, 0);
        chk("sim1_ls_rdata", ls_rdata, 32'hCAFE0001);
        tick();
        chk("sim2_mc_req", mc.mc_req, 1);
        chk("sim2_mc_addr", mc.mc_addr, 32'h200);
        chk("sim2_mc_is_if", mc.mc_is_if, 1);
        chk("sim2_ls_done_low", ls_done, 0);
        tick();
        mc.mc_done = 1; mc.mc_rdata = 32'h0BADF00D;
        tick();
        mc.mc_done = 0;
        chk("sim2_if_done", if_done, 1);
        chk("sim2_if_pc", if_pc, 32'h200);
        chk("sim2_if_inst", if_inst, 32'h0BADF00D);
        chk("sim2_ls_rdata_hold", ls_rdata, 32'hCAFE0001);

        // Starvation: LS slot refilled continuously, one IF waiting
        if_req = 1; if_addr = 32'h300;
        ls_req = 1; ls_addr = 32'h2000; ls_wdata = 32'h0; ls_type = 4'h0;
        tick();
        if_req = 0;
        ls_before = 0;
        got_if = 0;
        for (int t = 0; t < 6 && !got_if; t++) begin
            n = 0;
            while (mc.mc_req !== 1'b1 && n < 10) begin tick(); n++; end
            chk("stv_req_seen", mc.mc_req, 1);
            if (mc.mc_is_if === 1'b1) begin
                got_if = 1;
                chk("stv_if_addr", mc.mc_addr, 32'h300);
            end else begin
                ls_before++;
            end
            tick();
            mc.mc_done = 1; mc.mc_rdata = 32'h1000 + t;
            tick();
            mc.mc_done = 0;
            chk("stv_if_done_kind", if_done, got_if);
        end
        ls_req = 0;
        chk("stv_ls_before_if", ls_before, 3);
        chk("stv_if_issued", got_if, 1);
        chk("stv_if_inst", if_inst, 32'h1003);
        n = 0;
        while (mc.mc_req !== 1'b1 && n < 10) begin tick(); n++; end
        chk("stv_drain_is_ls", mc.mc_is_if, 0);
        tick();
        mc.mc_done = 1; mc.mc_rdata = 32'h77;
        tick();
        mc.mc_done = 0;
        chk("stv_drain_ls_done", ls_done, 1);
        tick();
        chk("stv_idle", arb_busy, 0);

        // Flush during WAIT of a fetch
        if_req = 1; if_addr = 32'h400;
        tick(); if_req = 0;
        tick(); tick();                           // select, handshake
        flush = 1;
        tick(); flush = 0;
        chk("fw_busy_drop", arb_busy, 1);
        tick();
        chk("fw_busy_drop2", arb_busy, 1);
        mc.mc_done = 1; mc.mc_rdata = 32'h12345678;
        tick(); mc.mc_done = 0;
        chk("fw_no_if_done", if_done, 0);
        chk("fw_idle", arb_busy, 0);
        chk("fw_inst_kept", if_inst, 32'h1003);
        tick();
        chk("fw_no_if_done2", if_done, 0);

        // Flush during ISSUE of a fetch (controller busy)
        mc.mc_busy = 1;
        if_req = 1; if_addr = 32'h500;
        tick(); if_req = 0;
        tick();
        chk("fi_mc_req", mc.mc_req, 1);
        flush = 1;
        tick(); flush = 0;
        chk("fi_mc_req_drop", mc.mc_req, 0);
        chk("fi_idle", arb_busy, 0);

        // if_req in a flush cycle is not accepted
        if_req = 1; if_addr = 32'h580; flush = 1;
        tick(); if_req = 0; flush = 0;
        chk("ff_if_ready", if_ready, 1);
        tick();
        chk("ff_no_issue", mc.mc_req, 0);

        // Backpressure with flush and stray mc_done: LS untouched
        ls_req = 1; ls_addr = 32'h3000; ls_wdata = 32'hA5; ls_type = 4'h1;
        tick(); ls_req = 0;
        tick();
        chk("bp_mc_req", mc.mc_req, 1);
        chk("bp_mc_is_if", mc.mc_is_if, 0);
        ls_req = 1; ls_addr = 32'h3100; flush = 1; mc.mc_done = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) ls_req = 0;
            chk("bp_hold_req", mc.mc_req, 1);
            chk("bp_hold_addr", mc.mc_addr, 32'h3000);
            chk("bp_no_ls_done", ls_done, 0);
        end
        flush = 0; mc.mc_done = 0; mc.mc_busy = 0;
        tick();
        chk("bp_handshake", mc.mc_req, 0);
        chk("bp_ls_slot_kept", ls_ready, 0);
        mc.mc_done = 1; mc.mc_rdata = 32'h55AA55AA;
        tick(); mc.mc_done = 0;
        chk("bp_ls_done", ls_done, 1);
        chk("bp_ls_rdata", ls_rdata, 32'h55AA55AA);
        tick();
        chk("bp2_mc_addr", mc.mc_addr, 32'h3100);
        tick();
        mc.mc_done = 1; mc.mc_rdata = 32'h66;
        tick(); mc.mc_done = 0;
        chk("bp2_ls_rdata", ls_rdata, 32'h66);
        tick();

        // flush coincides with mc_done in WAIT of a fetch
        if_req = 1; if_addr = 32'h600;
        tick(); if_req = 0;
        tick(); tick();
        flush = 1; mc.mc_done = 1; mc.mc_rdata = 32'h99;
        tick(); flush = 0; mc.mc_done = 0;
        chk("fd_no_if_done", if_done, 0);
        chk("fd_idle", arb_busy, 0);
        tick();
        chk("fd_no_if_done2", if_done, 0);

        // Asynchronous reset during WAIT of a store
        ls_req = 1; ls_addr = 32'h4000; ls_wdata = 32'h11; ls_type = 4'h3;
        tick(); ls_req = 0;
        tick(); tick();
        chk("ar_busy_before", arb_busy, 1);
        #2 rst = 0;
        #1;
        chk("ar_mc_addr", mc.mc_addr, 0);
        chk("ar_mc_wdata", mc.mc_wdata, 0);
        chk("ar_mc_type", mc.mc_type, 0);
        chk("ar_arb_busy", arb_busy, 0);
        chk("ar_ls_rdata", ls_rdata, 0);
        chk("ar_if_pc", if_pc, 0);
        chk("ar_ls_ready", ls_ready, 1);
        tick();
        rst = 1;
        mc.mc_done = 1; mc.mc_rdata = 32'hBB;
        tick(); mc.mc_done = 0;
        chk("ar_no_ls_done", ls_done, 0);
        tick();
        chk("ar_no_ls_done2", ls_done, 0);
        chk("ar_idle", arb_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
